combo_scheduler: RTL and testbench
==================================

COMBO_SCHEDULER -- requirements
Module: combo_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, default 4: number of combo sprite instances managed.
REQ-002 Parameter FIFO_DEPTH, default 4: pending-hit queue depth (power of 2).
REQ-003 Parameter COMBO_MAX, default 999: saturation value of combo counter.
REQ-004 frame_clk  in  1  clock; all logic on rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 hit_valid  in  1  one-frame pulse: note hit scored.
REQ-007 miss  in  1  one-frame pulse: note missed.
REQ-008 slot_busy  in  NUM_SLOTS  keep_on of each combo sprite instance.
REQ-009 slot_audio  in  NUM_SLOTS  audio_flag1 of each combo sprite instance.
REQ-010 slot_en  out  NUM_SLOTS  BallEN to each instance; one-hot one-frame launch pulse.
REQ-011 audio_start  out  1  one-frame pulse to audio player.
REQ-012 combo_count  out  10  current combo streak, binary.
REQ-013 fifo_full  out  1  pending queue holds FIFO_DEPTH entries.
REQ-014 drop_count  out  8  hits discarded due to full queue, saturating at 255.

Function
REQ-015 Combo counter: hit_valid increments by 1, saturating at COMBO_MAX; miss clears to 0.
REQ-016 hit_valid and miss same frame: miss wins, combo_count <- 0; hit is still enqueued.
REQ-017 Each hit_valid pushes one entry into the pending queue; push into full queue drops the hit and increments drop_count.
REQ-018 Queue push and pop in same frame while full: pop first, push accepted, occupancy unchanged, no drop.
REQ-019 Launch FSM states IDLE, LAUNCH, WAIT_ACK; reset state IDLE.
REQ-020 IDLE: if queue non-empty and any slot free, select slot, pop queue, go LAUNCH; else stay.
REQ-021 Slot free = slot_busy low and slot not held by WAIT_ACK; selection round-robin starting after last launched slot (slot 0 first after reset).
REQ-022 LAUNCH: assert slot_en for selected slot only, for exactly one frame; go WAIT_ACK.
REQ-023 WAIT_ACK: return to IDLE when selected slot_busy is high, or after 4 frames in WAIT_ACK (timeout).
REQ-024 Hit-to-slot_en latency: minimum 2 frames (push frame N, IDLE pop N+1, slot_en high N+2).
REQ-025 All slots busy: queue retains entries; launch resumes first frame a slot is free.
REQ-026 Audio: rising edge of slot_audio[i] sets pending bit i; edge detection uses registered previous value.
REQ-027 Each frame at most one pending bit granted, round-robin after last granted; grant clears bit and pulses audio_start for one frame.
REQ-028 Rising edge on already-pending slot is merged (no second pulse).
REQ-029 slot_en at most one bit high in any frame; audio_start never high two consecutive frames only if ≥2 pending.
REQ-030 fifo_full combinational from occupancy register; all other outputs registered.

Reset
REQ-031 Reset assertion immediately forces: slot_en=0, audio_start=0, combo_count=0, drop_count=0, queue empty, fifo_full=0, FSM IDLE, audio pending bits 0, round-robin pointers 0, edge registers 0.
REQ-032 Reset mid-LAUNCH or mid-WAIT_ACK aborts the launch; no slot_en pulse after deassertion until a new hit.

Verification
REQ-033 Single hit, all slots idle -> slot_en=0001 exactly at frame N+2, combo_count=1, FSM back to IDLE when slot_busy[0] rises.
REQ-034 6 hits in consecutive frames, slot_busy held 1111 -> fifo_full=1 after 4, drop_count=2, no slot_en until a slot frees.
REQ-035 Slots 0 and 2 free, last launch slot 0 -> next launch on slot 2, then slot 0.
REQ-036 slot_audio rises on slots 1 and 3 same frame -> audio_start pulses in 2 consecutive frames, slot 1 granted first after reset.
REQ-037 combo_count=999 plus hit -> stays 999; hit+miss same frame -> combo_count=0 and one entry enqueued.
REQ-038 slot_busy never rises after launch -> WAIT_ACK exits after 4 frames; Reset during WAIT_ACK -> all outputs 0 next frame.

Source files
------------

// File: rtl/combo_scheduler.sv
// Combo scheduler: tracks the hit streak, queues scored hits and launches them
// onto free combo sprite slots, and arbitrates sprite audio triggers to one player.
module combo_scheduler #(
    parameter int NUM_SLOTS  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int COMBO_MAX  = 999
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic                 hit_valid,
    input  logic                 miss,
    input  logic [NUM_SLOTS-1:0] slot_busy,
    input  logic [NUM_SLOTS-1:0] slot_audio,
    output logic [NUM_SLOTS-1:0] slot_en,
    output logic                 audio_start,
    output logic [9:0]           combo_count,
    output logic                 fifo_full,
    output logic [7:0]           drop_count
);

    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int OCC_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
    localparam logic [9:0]       COMBO_SAT = 10'(COMBO_MAX);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK} state_t;

    state_t               state;
    logic [OCC_W-1:0]     occ;
    logic [SLOT_W-1:0]    sel;
    logic [SLOT_W-1:0]    launch_rr;
    logic [SLOT_W-1:0]    launch_pick;
    logic [SLOT_W-1:0]    audio_rr;
    logic [SLOT_W-1:0]    audio_pick;
    logic [1:0]           wait_cnt;
    logic [NUM_SLOTS-1:0] slot_free;
    logic [NUM_SLOTS-1:0] slot_audio_p1;
    logic [NUM_SLOTS-1:0] audio_pend;
    logic [NUM_SLOTS-1:0] audio_rise;
    logic [NUM_SLOTS-1:0] grant_mask;
    logic                 pop;
    logic                 push_ok;
    logic                 audio_any;

    // First set bit of mask, scanning upward from start and wrapping.
    function automatic logic [SLOT_W-1:0] rr_pick(input logic [NUM_SLOTS-1:0] mask,
                                                  input logic [SLOT_W-1:0]    start);
        logic [SLOT_W-1:0] pick;
        logic [SLOT_W-1:0] cand;
        pick = '0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            cand = SLOT_W'((int'(start) + k) % NUM_SLOTS);
            if (mask[cand]) pick = cand;
        end
        return pick;
    endfunction

    function automatic logic [SLOT_W-1:0] rr_next(input logic [SLOT_W-1:0] idx);
        return SLOT_W'((int'(idx) + 1) % NUM_SLOTS);
    endfunction

    assign slot_free   = ~slot_busy;
    assign fifo_full   = (occ == OCC_FULL);
    assign pop         = (state == IDLE) && (occ != '0) && (|slot_free);
    assign push_ok     = hit_valid && (!fifo_full || pop);
    assign launch_pick = rr_pick(slot_free, launch_rr);
    assign audio_rise  = slot_audio & ~slot_audio_p1;
    assign audio_any   = |audio_pend;
    assign audio_pick  = rr_pick(audio_pend, audio_rr);
    assign grant_mask  = audio_any ? (NUM_SLOTS'(1) << audio_pick) : '0;

    // Launch FSM: pick a slot and pop in IDLE, pulse it in LAUNCH, then hold it
    // until the sprite acknowledges with keep_on or four frames pass.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            sel       <= '0;
            launch_rr <= '0;
            wait_cnt  <= '0;
            slot_en   <= '0;
        end else begin
            slot_en <= '0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        sel       <= launch_pick;
                        launch_rr <= rr_next(launch_pick);
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    slot_en  <= NUM_SLOTS'(1) << sel;
                    wait_cnt <= '0;
                    state    <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (slot_busy[sel] || wait_cnt == 2'd3) state <= IDLE;
                    else wait_cnt <= wait_cnt + 2'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pending-hit occupancy, combo streak and drop counter.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            occ         <= '0;
            combo_count <= '0;
            drop_count  <= '0;
        end else begin
            case ({push_ok, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (hit_valid && !push_ok && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
            if (miss)
                combo_count <= '0;
            else if (hit_valid && combo_count < COMBO_SAT)
                combo_count <= combo_count + 10'd1;
        end
    end

    // Audio arbitration: a grant clears its bit while a fresh edge re-arms it.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            slot_audio_p1 <= '0;
            audio_pend    <= '0;
            audio_rr      <= '0;
            audio_start   <= 1'b0;
        end else begin
            slot_audio_p1 <= slot_audio;
            audio_pend    <= (audio_pend & ~grant_mask) | audio_rise;
            audio_start   <= audio_any;
            if (audio_any) audio_rr <= rr_next(audio_pick);
        end
    end

endmodule

// File: tb/tb_combo_scheduler.sv
// Bench for combo_scheduler: directed scenarios with literal expectations plus
// randomized traffic compared every frame against a cycle-count based model.
module tb_combo_scheduler;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic       hit_valid;
    logic       miss;
    logic [3:0] slot_busy;
    logic [3:0] slot_audio;
    logic [3:0] slot_en;
    logic       audio_start;
    logic [9:0] combo_count;
    logic       fifo_full;
    logic [7:0] drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 frame_clk = ~frame_clk;

    combo_scheduler #(.NUM_SLOTS(4), .FIFO_DEPTH(4), .COMBO_MAX(999)) dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .hit_valid  (hit_valid),
        .miss       (miss),
        .slot_busy  (slot_busy),
        .slot_audio (slot_audio),
        .slot_en    (slot_en),
        .audio_start(audio_start),
        .combo_count(combo_count),
        .fifo_full  (fifo_full),
        .drop_count (drop_count)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue as a count, a launch as (slot, fire frame), audio as a pending set.
    int       m_cyc, m_q, m_combo, m_drop, m_rr, m_arr, m_sel, m_fire;
    bit       m_active;
    bit [3:0] m_pend, m_prev;
    int       exp_en, exp_aud;

    function automatic int first_set(input bit [3:0] mask, input int start);
        for (int k = 0; k < 4; k++) begin
            if (mask[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_q = 0; m_combo = 0; m_drop = 0; m_rr = 0; m_arr = 0;
        m_sel = 0; m_fire = 0; m_active = 0; m_pend = '0; m_prev = '0;
        exp_en = 0; exp_aud = 0;
    endtask

    task automatic model_step();
        bit [3:0] free;
        bit       take;
        int       p;
        int       g;
        m_cyc++;
        free   = ~slot_busy;
        exp_en = 0;
        take   = !m_active && m_q > 0 && free != 0;
        if (m_active) begin
            if (m_cyc == m_fire) exp_en = 1 << m_sel;
            else if (slot_busy[m_sel] || m_cyc - m_fire >= 4) m_active = 0;
        end else if (take) begin
            p        = first_set(free, m_rr);
            m_sel    = p;
            m_rr     = (p + 1) % 4;
            m_active = 1;
            m_fire   = m_cyc + 1;
        end
        if (take) m_q--;
        if (hit_valid) begin
            if (m_q < 4) m_q++;
            else if (m_drop < 255) m_drop++;
        end
        if (miss) m_combo = 0;
        else if (hit_valid && m_combo < 999) m_combo++;
        g       = first_set(m_pend, m_arr);
        exp_aud = (g >= 0) ? 1 : 0;
        if (g >= 0) begin
            m_pend[g] = 1'b0;
            m_arr     = (g + 1) % 4;
        end
        m_pend = m_pend | (slot_audio & ~m_prev);
        m_prev = slot_audio;
    endtask

    always @(posedge frame_clk) begin
        #1;
        if (Reset) model_reset();
        else model_step();
        check("slot_en",     int'(slot_en),     exp_en);
        check("audio_start", int'(audio_start), exp_aud);
        check("combo_count", int'(combo_count), m_combo);
        check("drop_count",  int'(drop_count),  m_drop);
        check("fifo_full",   int'(fifo_full),   (m_q == 4) ? 1 : 0);
    end

    task automatic step();
        @(posedge frame_clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gap;
        Reset = 1'b1; hit_valid = 1'b0; miss = 1'b0; slot_busy = '0; slot_audio = '0;
        step(); step();
        check("rst_slot_en", int'(slot_en), 0);
        check("rst_combo",   int'(combo_count), 0);
        check("rst_full",    int'(fifo_full), 0);
        check("rst_drop",    int'(drop_count), 0);
        check("rst_audio",   int'(audio_start), 0);
        Reset = 1'b0;

        // Single hit with all slots idle: slot 0 fires two frames after the push.
        hit_valid = 1'b1; step(); hit_valid = 1'b0;
        check("A_combo", int'(combo_count), 1);
        check("A_en_n0", int'(slot_en), 0);
        step(); check("A_en_n1", int'(slot_en), 0);
        step(); check("A_en_n2", int'(slot_en), 1);
        slot_busy = 4'b0001; step();
        check("A_en_n3", int'(slot_en), 0);

        // Slots 0 and 2 free after launching slot 0: slot 2 next, then slot 0 after timeout.
        slot_busy = 4'b1010; hit_valid = 1'b1; step(); step(); hit_valid = 1'b0;
        step(); check("B_first_slot", int'(slot_en), 4);
        for (gap = 1; gap <= 20; gap++) begin
            step();
            if (slot_en != 0) break;
        end
        check("B_timeout_gap", gap, 6);
        check("B_second_slot", int'(slot_en), 1);

        // All slots busy: queue fills after four hits, two further hits dropped.
        slot_busy = '0; repeat (8) step();
        slot_busy = 4'b1111; hit_valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            check("C_full", int'(fifo_full), (i >= 4) ? 1 : 0);
        end
        hit_valid = 1'b0;
        check("C_drop", int'(drop_count), 2);
        for (int i = 0; i < 3; i++) begin
            step(); check("C_no_launch", int'(slot_en), 0);
        end
        slot_busy = 4'b1011; step();
        check("C_full_after_pop", int'(fifo_full), 0);
        step(); check("C_resume_slot", int'(slot_en), 4);
        slot_busy = '0; repeat (40) step();

        // Reset while waiting for an acknowledge aborts the launch.
        hit_valid = 1'b1; step(); hit_valid = 1'b0; step(); step(); step();
        Reset = 1'b1; #1;
        check("D_rst_slot_en", int'(slot_en), 0);
        check("D_rst_combo",   int'(combo_count), 0);
        check("D_rst_full",    int'(fifo_full), 0);
        check("D_rst_drop",    int'(drop_count), 0);
        check("D_rst_audio",   int'(audio_start), 0);
        step(); Reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(); check("D_no_launch", int'(slot_en), 0);
        end

        // Two audio edges in one frame give two back-to-back pulses.
        slot_audio = 4'b1010; step(); check("E_aud0", int'(audio_start), 0);
        step(); check("E_aud1", int'(audio_start), 1);
        step(); check("E_aud2", int'(audio_start), 1);
        step(); check("E_aud3", int'(audio_start), 0);
        slot_audio = '0; step();

        // Saturation of the combo streak and of the drop counter.
        hit_valid = 1'b1; repeat (1000) step(); hit_valid = 1'b0;
        check("F_combo_sat", int'(combo_count), 999);
        check("F_drop_sat",  int'(drop_count), 255);

        // Hit and miss together clears the streak but still queues the hit.
        Reset = 1'b1; step(); Reset = 1'b0;
        slot_busy = 4'b1111; hit_valid = 1'b1; miss = 1'b1; step();
        check("G_combo_clear", int'(combo_count), 0);
        check("G_not_full",    int'(fifo_full), 0);
        miss = 1'b0; repeat (3) step(); hit_valid = 1'b0;
        check("G_full", int'(fifo_full), 1);
        check("G_combo", int'(combo_count), 3);
        slot_busy = '0;

        for (int i = 0; i < 2000; i++) begin
            hit_valid = ($urandom_range(0, 9) < 3);
            miss      = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) slot_busy = 4'($urandom);
            if ($urandom_range(0, 2) == 0) slot_audio = 4'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                Reset = 1'b1; step(); Reset = 1'b0;
            end
            step();
        end
        hit_valid = 1'b0; miss = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
